// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, add-3 constants and power-of-ten helper for bin2bcd_seq.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, OVF} state_e;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_INC    = 4'd3;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb dout = (din >= ADD3_THRESH) ? din + ADD3_INC : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// BIN2BCD_AUTO_EN defined: free-running, BIN is re-converted whenever the FSM is idle.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVERFLOW
);

    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);
    localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    bin_sr_q, bin_sr_d;
    logic [4*DIGITS-1:0] bcd_sr_q, bcd_sr_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                start_eff;

`ifdef BIN2BCD_AUTO_EN
    assign start_eff = 1'b1;
`else
    assign start_eff = START;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.din(bcd_sr_q[4*i +: 4]), .dout(bcd_adj[4*i +: 4]));
    end

    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start_eff) begin
                bin_sr_d = BIN;
                bcd_sr_d = '0;
                cnt_d    = '0;
                state_d  = (64'(BIN) >= LIMIT) ? OVF : SHIFT;
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(BIN_W - 1)) ? FINISH : SHIFT;
            end
            FINISH: begin
                bcd_d   = bcd_sr_q;
                ovf_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            OVF: begin
                bcd_d   = ALL9;
                ovf_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // The DONE cycle is already IDLE, so BUSY keeps it covered explicitly.
    assign BUSY     = (state_q != IDLE) | done_q;
    assign DONE     = done_q;
    assign BCD      = bcd_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] BIN = '0;
    logic        BUSY, DONE, OVERFLOW;
    logic [31:0] BCD;

    int checks = 0;
    int failures = 0;

    bin2bcd_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
        .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bcd_ref(input logic [31:0] v);
        logic [31:0] r, x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run(input string tag, input logic [31:0] b, input logic [31:0] exp_bcd,
                       input logic exp_ovf, input int exp_lat);
        int n;
        @(negedge CLK);
        START = 1'b1;
        BIN   = b;
        @(negedge CLK);
        START = 1'b0;
        BIN   = $urandom;
        n = 1;
        chk({tag, "_busy"}, 64'(BUSY), 64'd1);
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_bcd"}, 64'(BCD), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(OVERFLOW), 64'(exp_ovf));
        chk({tag, "_busy_done"}, 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        chk({tag, "_idle"}, 64'(BUSY), 64'd0);
        chk({tag, "_hold"}, 64'(BCD), 64'(exp_bcd));
    endtask

    initial begin
        int n, dones;
        logic [31:0] v;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
`ifdef BIN2BCD_AUTO_EN
        BIN = 32'd12345678;
        n = 0;
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("auto_first", 64'(DONE), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n = 1;
            while (!DONE && n < 100) begin
                @(negedge CLK);
                n++;
            end
            chk("auto_period", 64'(n), 64'd34);
            chk("auto_bcd", 64'(BCD), 64'h12345678);
            chk("auto_ovf", 64'(OVERFLOW), 64'd0);
        end
        BIN = 32'd100000000;
        repeat (40) @(negedge CLK);
        while (!DONE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        n = 1;
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("auto_ovf_period", 64'(n), 64'd2);
        chk("auto_ovf_bcd", 64'(BCD), 64'h99999999);
        chk("auto_ovf_flag", 64'(OVERFLOW), 64'd1);
`else
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("rst_busy", 64'(BUSY), 64'd0);
            chk("rst_done", 64'(DONE), 64'd0);
            chk("rst_bcd", 64'(BCD), 64'd0);
            chk("rst_ovf", 64'(OVERFLOW), 64'd0);
        end
        run("zero", 32'd0, 32'h00000000, 1'b0, 34);
        run("mid", 32'd12345678, 32'h12345678, 1'b0, 34);
        run("max", 32'd99999999, 32'h99999999, 1'b0, 34);
        run("ovf", 32'd100000000, 32'h99999999, 1'b1, 2);
        run("ovf_top", 32'hFFFFFFFF, 32'h99999999, 1'b1, 2);
        run("after_ovf", 32'd9, 32'h00000009, 1'b0, 34);
        for (int k = 0; k < 8; k++) begin
            v = $urandom_range(99999999, 0);
            run("rand", v, bcd_ref(v), 1'b0, 34);
        end
        // A second START mid-conversion must be dropped, not queued.
        @(negedge CLK);
        START = 1'b1;
        BIN   = 32'd42;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        START = 1'b1;
        BIN   = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            if (DONE) begin
                dones++;
                chk("dbl_bcd", 64'(BCD), 64'h00000042);
            end
            @(negedge CLK);
        end
        chk("dbl_count", 64'(dones), 64'd1);
        chk("dbl_hold", 64'(BCD), 64'h00000042);
        // Reset mid-conversion aborts with no DONE and clears outputs.
        @(negedge CLK);
        START = 1'b1;
        BIN   = 32'd42;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        chk("abort_done", 64'(dones), 64'd0);
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_bcd", 64'(BCD), 64'd0);
        chk("abort_ovf", 64'(OVERFLOW), 64'd0);
        // RST beats START in the same cycle.
        RST   = 1'b1;
        START = 1'b1;
        BIN   = 32'd5;
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("rst_wins_busy", 64'(BUSY), 64'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
